// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry micro-op FIFO with valid/ready on both sides.
// Optional DECODE_ILLEGAL_EN adds an out_illegal flag; op codes: NOP 0, LUI 1, AUIPC 2,
// JAL 3, JALR 4, BRANCH 8+f3, LOAD 16+f3, STORE 24+f3, OP-IMM 32+{f7b5&sr,f3}, OP 48+{f7b5,f3}.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [OP_W-1:0] out_op,
  output logic [31:0]     out_imm,
  output logic            out_en_rx,
  output logic            out_en_ry,
  output logic            out_en_w,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]     pc;
    logic [OP_W-1:0] op;
    logic [31:0]     imm;
    logic            en_rx;
    logic            en_ry;
    logic            en_w;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } uop_t;

  uop_t          dec, hd;
  uop_t          mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [2:0]    f3;
  logic          f7b;

  assign f3  = in_inst[14:12];
  assign f7b = in_inst[30];

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    case (in_inst[6:0])
      7'b0110111: begin dec.op = OP_W'(6'd1); dec.en_w = 1'b1; dec.imm = {in_inst[31:12], 12'b0}; end
      7'b0010111: begin dec.op = OP_W'(6'd2); dec.en_w = 1'b1; dec.imm = {in_inst[31:12], 12'b0}; end
      7'b1101111: begin
        dec.op   = OP_W'(6'd3);
        dec.en_w = 1'b1;
        dec.imm  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        dec.op = OP_W'(6'd4); dec.en_rx = 1'b1; dec.en_w = 1'b1;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b1100011: begin
        dec.op = OP_W'({3'b001, f3}); dec.en_rx = 1'b1; dec.en_ry = 1'b1;
        dec.imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0000011: begin
        dec.op = OP_W'({3'b010, f3}); dec.en_rx = 1'b1; dec.en_w = 1'b1;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec.op = OP_W'({3'b011, f3}); dec.en_rx = 1'b1; dec.en_ry = 1'b1;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      // f7 bit 5 only distinguishes SRAI from SRLI among immediate ops
      7'b0010011: begin
        dec.op = OP_W'({2'b10, (f3 == 3'b101) & f7b, f3}); dec.en_rx = 1'b1; dec.en_w = 1'b1;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0110011: begin
        dec.op = OP_W'({2'b11, f7b, f3}); dec.en_rx = 1'b1; dec.en_ry = 1'b1; dec.en_w = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
    dec.rs1 = dec.en_rx ? in_inst[19:15] : 5'd0;
    dec.rs2 = dec.en_ry ? in_inst[24:20] : 5'd0;
    dec.rd  = dec.en_w  ? in_inst[11:7]  : 5'd0;
  end

  assign in_ready  = !rst && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = rdy & in_valid & in_ready & ~flush;
  assign pop       = rdy & out_valid & out_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
      if (pop)  head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec;
  end

  // Empty queue shows all-zero fields so consumers never see stale entries
  always_comb begin
    hd = '0;
    if (out_valid) hd = mem_q[head_q];
  end

  assign out_pc    = hd.pc;
  assign out_op    = hd.op;
  assign out_imm   = hd.imm;
  assign out_en_rx = hd.en_rx;
  assign out_en_ry = hd.en_ry;
  assign out_en_w  = hd.en_w;
  assign out_rs1   = hd.rs1;
  assign out_rs2   = hd.rs2;
  assign out_rd    = hd.rd;
`ifdef DECODE_ILLEGAL_EN
  assign out_illegal = hd.illegal;
`endif
endmodule
